udp_tx_scheduler: RTL and testbench
===================================

# udp_tx_scheduler

Shares the single UDP transmitter between two sources: the ADC sample FIFO (bulk) and the FFT frequency result (short, priority). Decides when a packet goes out: sample FIFO reaches packet size, sample flush timeout, or new result. Sequences the `udp_tx_start` / word-request / done handshake. Sits between the data-processing FSM / sample FIFO and the UDP TX core.

## Interface
- `FIFO_AW`, 11, sample FIFO address width; fill count is FIFO_AW+1 bits
- `PKT_WORDS`, 512, sample words per full sample packet (1..2^FIFO_AW)
- `FLUSH_TIMEOUT`, 50_000_000, idle cycles before a partial sample packet is flushed; 0 disables flush
- `clk`  in  1  system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `fifo_rd_count`  in  FIFO_AW+1  sample FIFO fill level
- `fifo_rd_en`  out  1  FIFO read strobe; 1-cycle read latency
- `fifo_rd_data`  in  16  FIFO read data
- `res_valid`  in  1  1-cycle pulse, new FFT result
- `res_freq`  in  32  frequency result, sampled on `res_valid`
- `res_amp`  in  16  peak amplitude, sampled on `res_valid`
- `res_drop_cnt`  out  16  saturating count of overwritten unsent results
- `udp_tx_ready`  in  1  UDP core idle
- `udp_tx_start`  out  1  1-cycle packet start pulse
- `udp_tx_len`  out  16  packet payload length in bytes
- `udp_data_req`  in  1  UDP core requests next 16-bit word
- `udp_tx_data`  out  16  payload word, valid cycle after `udp_data_req`
- `udp_tx_done`  in  1  UDP core finished packet
- `busy`  out  1  high outside IDLE

## Operation
- States: IDLE, START, SEND, WAIT_DONE.
- Result capture: `res_valid` loads pending regs and sets `res_pending`. If already pending, overwrite (latest wins) and `res_drop_cnt`+1, saturating at 0xFFFF. START copies pending → send regs and clears `res_pending`. A `res_valid` in the same cycle as START re-sets pending with the new value and is not counted as a drop.
- Sample eligibility: `fifo_rd_count >= PKT_WORDS` gives N=PKT_WORDS. Flush: timer expired and count>0 gives N=count captured at START.
- Flush timer (32-bit): increments in IDLE while 0<count<PKT_WORDS. Clears on START, on count=0, and outside IDLE. Expired at value ≥ FLUSH_TIMEOUT.
- IDLE→START when `udp_tx_ready` and either source is eligible. Result wins when both are eligible. No preemption.
- START: `udp_tx_start`=1 for one cycle; `udp_tx_len` and source latched. Go to SEND.
- Packet layout: word 0 is header {type[3:0], seq[11:0]}.
  - Result packet: res_freq[31:16], res_freq[15:0], res_amp; len=8.
  - Sample packet: N samples; len=2(N+1).
- SEND: word index counts `udp_data_req`. For sample words (index 1..N), `fifo_rd_en` = `udp_data_req`, combinational. After the last word is requested, go to WAIT_DONE. Further requests return 0 and never read the FIFO.
- WAIT_DONE→IDLE on `udp_tx_done`. `udp_tx_done` in other states is ignored. `udp_data_req` outside SEND is ignored; data is 0.
- Reset outputs: `fifo_rd_en`=0, `udp_tx_start`=0, `udp_tx_len`=0, `udp_tx_data`=0, `res_drop_cnt`=0, `busy`=0, state IDLE, pending cleared, seq=0, timer=0.

## Timing
- Eligible + ready in IDLE (cycle t) → `udp_tx_start` at t+1 → SEND at t+2.
- Request in cycle k → `udp_tx_data` valid in cycle k+1, registered for header/result words and from `fifo_rd_data` for samples.
- `udp_tx_len` is held from START until leaving WAIT_DONE.
- Back-to-back: from `udp_tx_done`, the next START follows 2 cycles later at earliest.

## Configuration
- `UDP_TX_SEQ_EN` defined: 12-bit seq counter in header; +1 per START, wraps 0xFFF→0.
- Not defined: header seq field is 0; no counter logic.

## Structure
- Package `udp_pkt_pkg`: state enum, `PKT_TYPE_SAMPLES`=4'h1, `PKT_TYPE_RESULT`=4'h2, header-pack function.
- Sub-module `udp_flush_timer`: timer compare and expiry.

## Test plan
- count=512, ready=1 → one start, len=1026. 512 `fifo_rd_en` pulses. Header 0x1000 (seq 0).
- FLUSH_TIMEOUT=100, count=7 static → start after 100 cycles, len=16, 7 reads.
- `res_valid` (freq=0x00012345, amp=0x0ABC) with count=600 → result first: len=8, words 0x2000,0x0001,0x2345,0x0ABC. Then sample packet, seq=1.
- Three `res_valid` pulses while ready=0 → `res_drop_cnt`=2, last value sent.
- Extra `udp_data_req` past last word → `udp_tx_data`=0, no `fifo_rd_en`.
- `reset_n` low mid-SEND → all outputs at reset values, IDLE. Normal send after release.

Source files
------------

// File: rtl/udp_pkt_pkg.sv
// Shared types for the UDP transmit scheduler: FSM states, packet type codes
// and the header word layout {type[3:0], seq[11:0]}.
package udp_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        SEND      = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    localparam logic [3:0] PKT_TYPE_SAMPLES = 4'h1;
    localparam logic [3:0] PKT_TYPE_RESULT  = 4'h2;

    function automatic logic [15:0] pack_header(input logic [3:0] pkt_type, input logic [11:0] seq);
        return {pkt_type, seq};
    endfunction

endpackage

// File: rtl/udp_flush_timer.sv
// Idle timer for partial sample packets; expired once it reaches FLUSH_TIMEOUT.
// A FLUSH_TIMEOUT of 0 means the timer never expires.
module udp_flush_timer #(
    parameter int unsigned FLUSH_TIMEOUT = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam logic [31:0] TIMEOUT = FLUSH_TIMEOUT;

    logic [31:0] timer_q;

    // Stops counting once expired so it can never wrap back below the threshold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else if (clear) begin
            timer_q <= '0;
        end else if (run && !expired) begin
            timer_q <= timer_q + 32'd1;
        end
    end

    assign expired = (TIMEOUT != 32'd0) && (timer_q >= TIMEOUT);

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares one UDP transmitter between bulk ADC samples and priority FFT results.
// Define UDP_TX_SEQ_EN to carry a 12-bit packet sequence number in the header.
module udp_tx_scheduler
    import udp_pkt_pkg::*;
#(
    parameter int          FIFO_AW       = 11,
    parameter int          PKT_WORDS     = 512,
    parameter int unsigned FLUSH_TIMEOUT = 50_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [FIFO_AW:0] fifo_rd_count,
    output logic             fifo_rd_en,
    input  logic [15:0]      fifo_rd_data,
    input  logic             res_valid,
    input  logic [31:0]      res_freq,
    input  logic [15:0]      res_amp,
    output logic [15:0]      res_drop_cnt,
    input  logic             udp_tx_ready,
    output logic             udp_tx_start,
    output logic [15:0]      udp_tx_len,
    input  logic             udp_data_req,
    output logic [15:0]      udp_tx_data,
    input  logic             udp_tx_done,
    output logic             busy,
    output state_e           state_dbg
);

    // Handshake: udp_tx_start pulses one cycle with udp_tx_len valid; each
    // udp_data_req in SEND is answered with udp_tx_data on the next cycle;
    // udp_tx_done in WAIT_DONE releases the transmitter back to IDLE.
    localparam int CW = FIFO_AW + 1;
    localparam int IW = CW + 1;
    localparam logic [CW-1:0] PKT_N = CW'(PKT_WORDS);

    state_e        state_q, state_d;
    logic          res_pending_q, src_res_q, sample_sel_q;
    logic [31:0]   pend_freq_q, send_freq_q;
    logic [15:0]   pend_amp_q, send_amp_q, drop_q, len_q, data_q, word_mux;
    logic [CW-1:0] n_words_q, sample_n;
    logic [IW-1:0] word_idx_q, last_idx;
    logic [11:0]   hdr_seq;
    logic          flush_expired, sample_full, sample_elig, go, start_cyc, res_start, req_ok;

    assign sample_full = fifo_rd_count >= PKT_N;
    assign sample_elig = sample_full || (flush_expired && fifo_rd_count != '0);
    assign sample_n    = sample_full ? PKT_N : fifo_rd_count;
    assign go          = (state_q == IDLE) && udp_tx_ready && (res_pending_q || sample_elig);
    assign start_cyc   = (state_q == START);
    assign res_start   = start_cyc && src_res_q;
    assign req_ok      = (state_q == SEND) && udp_data_req;
    assign last_idx    = src_res_q ? IW'(3) : {1'b0, n_words_q};
    assign fifo_rd_en  = req_ok && !src_res_q && (word_idx_q != '0);

    udp_flush_timer #(.FLUSH_TIMEOUT(FLUSH_TIMEOUT)) u_flush_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .run     ((state_q == IDLE) && (fifo_rd_count != '0) && !sample_full),
        .clear   ((state_q != IDLE) || (fifo_rd_count == '0)),
        .expired (flush_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (go) state_d = START;
            START:     state_d = SEND;
            SEND:      if (udp_data_req && word_idx_q == last_idx) state_d = WAIT_DONE;
            WAIT_DONE: if (udp_tx_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // A result arriving during its own START cycle becomes the next pending result, not a drop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_pending_q <= 1'b0;
            pend_freq_q   <= '0;
            pend_amp_q    <= '0;
            send_freq_q   <= '0;
            send_amp_q    <= '0;
            drop_q        <= '0;
        end else begin
            if (res_start) begin
                send_freq_q <= pend_freq_q;
                send_amp_q  <= pend_amp_q;
            end
            if (res_valid) begin
                pend_freq_q   <= res_freq;
                pend_amp_q    <= res_amp;
                res_pending_q <= 1'b1;
                if (res_pending_q && !res_start && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end else if (res_start) begin
                res_pending_q <= 1'b0;
            end
        end
    end

    always_comb begin
        word_mux = '0;
        if (word_idx_q == '0) begin
            word_mux = pack_header(src_res_q ? PKT_TYPE_RESULT : PKT_TYPE_SAMPLES, hdr_seq);
        end else if (src_res_q) begin
            case (word_idx_q)
                IW'(1):  word_mux = send_freq_q[31:16];
                IW'(2):  word_mux = send_freq_q[15:0];
                IW'(3):  word_mux = send_amp_q;
                default: word_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_res_q    <= 1'b0;
            n_words_q    <= '0;
            len_q        <= '0;
            word_idx_q   <= '0;
            data_q       <= '0;
            sample_sel_q <= 1'b0;
        end else begin
            sample_sel_q <= fifo_rd_en;
            data_q       <= '0;
            if (go) begin
                src_res_q <= res_pending_q;
                n_words_q <= sample_n;
                len_q     <= res_pending_q ? 16'd8 : 16'((32'(sample_n) + 32'd1) << 1);
            end
            if (start_cyc) begin
                word_idx_q <= '0;
            end else if (req_ok) begin
                word_idx_q <= word_idx_q + IW'(1);
                data_q     <= word_mux;
            end
        end
    end

`ifdef UDP_TX_SEQ_EN
    logic [11:0] seq_q, hdr_seq_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_q     <= '0;
            hdr_seq_q <= '0;
        end else if (start_cyc) begin
            hdr_seq_q <= seq_q;
            seq_q     <= seq_q + 12'd1;
        end
    end

    assign hdr_seq = hdr_seq_q;
`else
    assign hdr_seq = '0;
`endif

    assign udp_tx_start = start_cyc;
    assign udp_tx_len   = len_q;
    assign udp_tx_data  = sample_sel_q ? fifo_rd_data : data_q;
    assign res_drop_cnt = drop_q;
    assign busy         = (state_q != IDLE);
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Randomized bench for udp_tx_scheduler: FIFO and UDP-core models drive the DUT,
// a packet-level reference model fills the expected word queue.
module tb_udp_tx_scheduler;
    import udp_pkt_pkg::*;

    localparam int FIFO_AW       = 11;
    localparam int PKT_WORDS     = 512;
    localparam int FLUSH_TIMEOUT = 100;
    localparam int NSAMP         = 16384;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [FIFO_AW:0] fifo_rd_count;
    logic             fifo_rd_en;
    logic [15:0]      fifo_rd_data = '0;
    logic             res_valid = 1'b0;
    logic [31:0]      res_freq = '0;
    logic [15:0]      res_amp = '0;
    logic [15:0]      res_drop_cnt;
    logic             udp_tx_ready = 1'b0;
    logic             udp_tx_start;
    logic [15:0]      udp_tx_len;
    logic             udp_data_req = 1'b0;
    logic [15:0]      udp_tx_data;
    logic             udp_tx_done = 1'b0;
    logic             busy;
    state_e           state_dbg;

    udp_tx_scheduler #(
        .FIFO_AW(FIFO_AW), .PKT_WORDS(PKT_WORDS), .FLUSH_TIMEOUT(FLUSH_TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .fifo_rd_count(fifo_rd_count), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .res_valid(res_valid), .res_freq(res_freq), .res_amp(res_amp), .res_drop_cnt(res_drop_cnt),
        .udp_tx_ready(udp_tx_ready), .udp_tx_start(udp_tx_start), .udp_tx_len(udp_tx_len),
        .udp_data_req(udp_data_req), .udp_tx_data(udp_tx_data), .udp_tx_done(udp_tx_done),
        .busy(busy), .state_dbg(state_dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Sample FIFO model: one-cycle read latency, data taken from a random table
    logic [15:0] samples [NSAMP];
    int pushed = 0;
    int popped = 0;

    assign fifo_rd_count = (FIFO_AW + 1)'(pushed - popped);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= samples[popped % NSAMP];
            popped <= popped + 1;
        end
    end

    // Scoreboard and packet-level reference model
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q[$];
    int          exp_len;
    int          exp_reads;
    int          model_ptr = 0;
    logic [11:0] model_seq = '0;
    bit          res_pend = 1'b0;
    logic [31:0] pend_f;
    logic [15:0] pend_a;
    int          model_drops = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int model_count();
        return pushed - model_ptr;
    endfunction

    function automatic logic [15:0] model_hdr(input logic [3:0] t);
`ifdef UDP_TX_SEQ_EN
        return {t, model_seq};
`else
        return {t, 12'h000};
`endif
    endfunction

    task automatic expect_result(input logic [31:0] f, input logic [15:0] a);
        exp_q.push_back(model_hdr(4'h2));
        exp_q.push_back(f[31:16]);
        exp_q.push_back(f[15:0]);
        exp_q.push_back(a);
        exp_len = 8;
        exp_reads = 0;
        model_seq = model_seq + 12'd1;
    endtask

    task automatic expect_samples(input int n);
        exp_q.push_back(model_hdr(4'h1));
        for (int i = 0; i < n; i++) exp_q.push_back(samples[(model_ptr + i) % NSAMP]);
        model_ptr += n;
        exp_len = 2 * (n + 1);
        exp_reads = n;
        model_seq = model_seq + 12'd1;
    endtask

    // Result has priority; otherwise a full packet, otherwise a flush of what is left.
    task automatic expect_next();
        if (res_pend) begin
            res_pend = 1'b0;
            expect_result(pend_f, pend_a);
        end else if (model_count() >= PKT_WORDS) begin
            expect_samples(PKT_WORDS);
        end else begin
            expect_samples(model_count());
        end
    endtask

    // Driver tasks (called on a falling edge)
    task automatic push_samples(input int n);
        pushed += n;
    endtask

    task automatic res_pulse(input logic [31:0] f, input logic [15:0] a);
        res_valid = 1'b1;
        res_freq = f;
        res_amp = a;
        @(negedge clk);
        res_valid = 1'b0;
        if (res_pend) model_drops = (model_drops == 65535) ? 65535 : model_drops + 1;
        res_pend = 1'b1;
        pend_f = f;
        pend_a = a;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rd_en"}, fifo_rd_en, 0);
        check_eq({tag, "_start"}, udp_tx_start, 0);
        check_eq({tag, "_len"}, udp_tx_len, 0);
        check_eq({tag, "_data"}, udp_tx_data, 0);
        check_eq({tag, "_drops"}, res_drop_cnt, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    // UDP core model: waits for start, requests every word, optional extra requests, done.
    task automatic send_packet(input int extra, input bit inject, output int wait_cycles);
        int w = 0;
        bit seen = 1'b0;
        int p0;
        int nw;
        logic [15:0] exp_word;
        logic [31:0] f;
        logic [15:0] a;
        while (w < 3000 && !seen) begin
            @(negedge clk);
            w++;
            seen = udp_tx_start;
        end
        wait_cycles = w;
        check_eq("start_seen", seen, 1);
        if (!seen) begin
            exp_q.delete();
            return;
        end
        check_eq("tx_len", udp_tx_len, exp_len);
        check_eq("busy_start", busy, 1);
        if (inject) begin
            f = $urandom;
            a = 16'($urandom);
            res_valid = 1'b1;
            res_freq = f;
            res_amp = a;
        end
        @(negedge clk);
        if (inject) begin
            res_valid = 1'b0;
            res_pend = 1'b1;
            pend_f = f;
            pend_a = a;
        end
        p0 = popped;
        nw = exp_q.size();
        for (int i = 0; i < nw; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            udp_data_req = 1'b1;
            #1;
            check_eq("rd_en_word", fifo_rd_en, (exp_reads > 0 && i > 0) ? 1 : 0);
            @(negedge clk);
            udp_data_req = 1'b0;
            exp_word = exp_q.pop_front();
            check_eq("tx_word", udp_tx_data, exp_word);
        end
        check_eq("fifo_reads", popped - p0, exp_reads);
        check_eq("state_wait_done", 32'(state_dbg), 32'(WAIT_DONE));
        for (int e = 0; e < extra; e++) begin
            udp_data_req = 1'b1;
            #1;
            check_eq("extra_rd_en", fifo_rd_en, 0);
            @(negedge clk);
            udp_data_req = 1'b0;
            check_eq("extra_data", udp_tx_data, 0);
        end
        check_eq("len_held", udp_tx_len, exp_len);
        udp_tx_done = 1'b1;
        @(negedge clk);
        udp_tx_done = 1'b0;
        check_eq("busy_after_done", busy, 0);
    endtask

    task automatic drain();
        int w;
        int guard = 0;
        while ((res_pend || model_count() > 0) && guard < 20) begin
            expect_next();
            send_packet($urandom_range(0, 2), 1'b0, w);
            guard++;
        end
    endtask

    // Main sequence
    initial begin
        int w;
        int n;
        int r;
        int p0;
        bit seen;

        for (int i = 0; i < NSAMP; i++) samples[i] = 16'($urandom);

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset_n = 1'b1;
        @(negedge clk);

        // Full sample packet
        udp_tx_ready = 1'b1;
        push_samples(PKT_WORDS);
        expect_next();
        send_packet(2, 1'b0, w);

        // Flush of a static partial fill
        push_samples(7);
        expect_next();
        send_packet(1, 1'b0, w);
        check_eq("flush_delay", w, FLUSH_TIMEOUT + 1);

        // Result beats a full FIFO
        udp_tx_ready = 1'b0;
        push_samples(600);
        res_pulse(32'h0001_2345, 16'h0ABC);
        check_eq("drops_single", res_drop_cnt, 0);
        udp_tx_ready = 1'b1;
        drain();

        // Overwritten results, plus a new result landing in the START cycle
        udp_tx_ready = 1'b0;
        for (int j = 0; j < 3; j++) res_pulse($urandom, 16'($urandom));
        check_eq("drops_triple", res_drop_cnt, 2);
        udp_tx_ready = 1'b1;
        expect_next();
        send_packet(0, 1'b1, w);
        check_eq("drops_after_inject", res_drop_cnt, model_drops);
        drain();

        // Random mixes of sample fills and results
        for (int it = 0; it < 6; it++) begin
            udp_tx_ready = 1'b0;
            n = $urandom_range(0, 700);
            if (n > 0) push_samples(n);
            r = $urandom_range(0, 2);
            for (int j = 0; j < r; j++) res_pulse($urandom, 16'($urandom));
            if (n == 0 && r == 0) res_pulse($urandom, 16'($urandom));
            @(negedge clk);
            udp_tx_ready = 1'b1;
            drain();
            check_eq("rand_drops", res_drop_cnt, model_drops);
        end

        // Reset in the middle of a sample packet
        push_samples(PKT_WORDS);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = udp_tx_start;
        end
        check_eq("rst_start_seen", seen, 1);
        @(negedge clk);
        p0 = popped;
        udp_data_req = 1'b1;
        repeat (10) @(negedge clk);
        udp_data_req = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_send");
        check_eq("rst_reads", popped - p0, 9);
        model_ptr += 9;
        model_seq = '0;
        res_pend = 1'b0;
        model_drops = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drain();
        check_eq("post_rst_drops", res_drop_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
